// File: rtl/cpu_boot_seq.sv
// Boot sequencer for the embedded stack CPU: it streams a host image into
// code memory, verifies the trailing checksum, then releases the CPU to run.
module cpu_boot_seq #(
    parameter int LOAD_WORDS = 1024,
    parameter int ADDR_W     = 11,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cmd,
    input  logic              cmd_vld,
    input  logic [15:0]       hd,
    input  logic              hd_vld,
    output logic              hd_rdy,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic [15:0]       load_data,
    output logic [1:0]        cpu_rst,
    output logic              boot_done,
    output logic              err,
    output logic [2:0]        state
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_RUN   = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [15:0]       csum_q, csum_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;
    logic              loaded_q, loaded_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;

    logic cmd_act, start_req, run_req, stop_req, accepting, xfer;

    assign cmd_act   = cmd_vld && (cmd != CMD_NOP);
    assign start_req = cmd_vld && (cmd == CMD_START);
    assign run_req   = cmd_vld && (cmd == CMD_RUN);
    assign stop_req  = cmd_vld && (cmd == CMD_STOP);
    assign accepting = (state_q == S_LOAD) || (state_q == S_CHK);

    // A live command always beats a data transfer in the same cycle.
    assign hd_rdy = accepting && !cmd_act;
    assign xfer   = hd_vld && hd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            csum_q   <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            to_q     <= to_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        to_d     = to_q;
        err_d    = err_q;
        loaded_d = loaded_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        if (start_req) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            csum_d  = '0;
            to_d    = '0;
            err_d   = 1'b0;
        end else if (stop_req && state_q != S_ERR) begin
            // An interrupted load leaves memory half-written, so forget the old image.
            if (accepting) begin
                loaded_d = 1'b0;
            end
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run_req) begin
                        if (loaded_q) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q;
                        data_d = hd;
                        csum_d = csum_q + hd;
                        to_d   = '0;
                        if (cnt_q == LAST_ADDR) begin
                            state_d = S_CHK;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end else if (to_q == TO_LAST) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        to_d = '0;
                        if (hd == csum_q) begin
                            state_d  = S_DONE;
                            loaded_d = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end else if (to_q == TO_LAST) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                S_DONE:  state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rst = 2'b00;
        unique case (state_q)
            S_LOAD, S_CHK, S_DONE: cpu_rst = 2'b01;
            S_RUN:                 cpu_rst = 2'b11;
            default:               cpu_rst = 2'b00;
        endcase
    end

    // The pending write of the previous transfer is squashed by a stop.
    assign load_we   = we_q && !stop_req;
    assign load_addr = addr_q;
    assign load_data = data_q;
    assign boot_done = (state_q == S_DONE);
    assign err       = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Bench for cpu_boot_seq: a vector table, directed boot scenarios and a random
// run, all checked cycle by cycle against a behavioural model of the sequencer.
module tb_cpu_boot_seq;

    localparam int LOAD_WORDS = 1024;
    localparam int ADDR_W     = 11;
    localparam int TIMEOUT    = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cmd = 2'd0;
    logic              cmd_vld = 1'b0;
    logic [15:0]       hd = 16'd0;
    logic              hd_vld = 1'b0;
    logic              hd_rdy;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic [1:0]        cpu_rst;
    logic              boot_done;
    logic              err;
    logic [2:0]        state;

    cpu_boot_seq #(
        .LOAD_WORDS(LOAD_WORDS),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .hd       (hd),
        .hd_vld   (hd_vld),
        .hd_rdy   (hd_rdy),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .cpu_rst  (cpu_rst),
        .boot_done(boot_done),
        .err      (err),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [1:0]  c;
        logic        hv;
        logic [15:0] d;
        logic [2:0]  st;
        logic        rdy;
        logic        we;
        logic [10:0] addr;
        logic [15:0] data;
        logic [1:0]  crst;
        logic        bd;
        logic        er;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: phase per the published encoding, words accepted so
    // far, running sum, and the cycle index of the last host activity.
    int m_st, m_words, m_sum, m_last, m_waddr, m_wdata;
    int cyc = 0;
    bit m_err, m_loaded, m_pend;

    int          wr_cnt, bd_cnt;
    logic [2:0]  s_state;
    logic        s_err;
    logic [1:0]  s_crst;

    function automatic logic [35:0] model_out(input bit cv, input logic [1:0] c);
        logic       rdy, we, bd;
        logic [1:0] cr;
        rdy = (m_st == 1 || m_st == 2) && !(cv && c != 2'd0);
        we  = m_pend && !(cv && c == 2'd3);
        cr  = (m_st == 4) ? 2'b11 : ((m_st >= 1 && m_st <= 3) ? 2'b01 : 2'b00);
        bd  = (m_st == 3);
        return {3'(m_st), rdy, we, 11'(m_waddr), 16'(m_wdata), cr, bd, m_err};
    endfunction

    function automatic logic [35:0] dut_out();
        return {state, hd_rdy, load_we, load_addr, load_data, cpu_rst, boot_done, err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_words = 0; m_sum = 0; m_last = cyc;
        m_waddr = 0; m_wdata = 0;
        m_err = 1'b0; m_loaded = 1'b0; m_pend = 1'b0;
    endtask

    task automatic timeout_rule();
        if (cyc - m_last == TIMEOUT) begin
            m_st  = 5;
            m_err = 1'b1;
        end
    endtask

    task automatic model_step(input bit cv, input logic [1:0] c, input bit hv, input logic [15:0] d);
        bit xfer;
        cyc++;
        xfer   = hv && (m_st == 1 || m_st == 2) && !(cv && c != 2'd0);
        m_pend = 1'b0;
        if (cv && c == 2'd1) begin
            m_st = 1; m_words = 0; m_sum = 0; m_last = cyc; m_err = 1'b0;
        end else if (cv && c == 2'd3 && m_st != 5) begin
            if (m_st == 1 || m_st == 2) m_loaded = 1'b0;
            m_st = 0;
        end else begin
            case (m_st)
                0: if (cv && c == 2'd2) begin
                    if (m_loaded) m_st = 4;
                    else begin m_st = 5; m_err = 1'b1; end
                end
                1: if (xfer) begin
                    m_pend  = 1'b1;
                    m_waddr = m_words;
                    m_wdata = int'(d);
                    m_sum   = (m_sum + int'(d)) % 65536;
                    m_words++;
                    m_last  = cyc;
                    if (m_words == LOAD_WORDS) m_st = 2;
                end else timeout_rule();
                2: if (xfer) begin
                    m_last = cyc;
                    if (int'(d) == m_sum) begin m_st = 3; m_loaded = 1'b1; end
                    else begin m_st = 5; m_err = 1'b1; end
                end else timeout_rule();
                3: m_st = 4;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit cv, input logic [1:0] c, input bit hv, input logic [15:0] d);
        @(negedge clk);
        cmd_vld = cv; cmd = c; hd_vld = hv; hd = d;
        #1;
        chk($sformatf("cycle %0d outputs", cyc + 1), 64'(dut_out()), 64'(model_out(cv, c)));
        s_state = state; s_err = err; s_crst = cpu_rst;
        if (load_we) wr_cnt++;
        if (boot_done) bd_cnt++;
        model_step(cv, c, hv, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_vld = 1'b0; cmd = 2'd0; hd_vld = 1'b0; hd = 16'd0;
        rst_n = 1'b0;
        #1;
        chk("reset outputs", 64'(dut_out()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic stream_count(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b1, 16'(i));
    endtask

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   words, sum, t, edges, i;
        bit   found, cv, hv;
        logic [1:0]  c;
        logic [15:0] d;

        //          cv    cmd   hv    hd        st    rdy   we    addr   data      crst   bd    err
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 11'd0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 11'd0, 16'h0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 3'd5, 1'b0, 1'b0, 11'd0, 16'h0000, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 16'hAAAA, 3'd5, 1'b0, 1'b0, 11'd0, 16'h0000, 2'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 16'h1234, 3'd1, 1'b1, 1'b0, 11'd0, 16'h0000, 2'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 16'h5678, 3'd1, 1'b1, 1'b1, 11'd0, 16'h1234, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'd0, 1'b1, 16'h9ABC, 3'd1, 1'b1, 1'b1, 11'd1, 16'h5678, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 16'hFFFF, 3'd1, 1'b0, 1'b1, 11'd2, 16'h9ABC, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 16'h0042, 3'd1, 1'b1, 1'b0, 11'd2, 16'h9ABC, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 16'h0043, 3'd1, 1'b0, 1'b0, 11'd0, 16'h0042, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 16'h0044, 3'd0, 1'b0, 1'b0, 11'd0, 16'h0042, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 11'd0, 16'h0042, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 16'h0000, 3'd5, 1'b0, 1'b0, 11'd0, 16'h0042, 2'd0, 1'b0, 1'b1};

        do_reset();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            cmd_vld = tbl[k].cv; cmd = tbl[k].c; hd_vld = tbl[k].hv; hd = tbl[k].d;
            #1;
            chk($sformatf("tbl[%0d]", k), 64'(dut_out()),
                64'({tbl[k].st, tbl[k].rdy, tbl[k].we, tbl[k].addr, tbl[k].data,
                     tbl[k].crst, tbl[k].bd, tbl[k].er}));
        end

        // Good image: words 0..1023 and checksum 0xFE00.
        do_reset();
        wr_cnt = 0; bd_cnt = 0;
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        stream_count(LOAD_WORDS);
        cycle(1'b0, 2'd0, 1'b1, 16'hFE00);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("good load DONE state", 64'(s_state), 64'd3);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("good load cpu_rst run", 64'(s_crst), 64'd3);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("good load write count", 64'(wr_cnt), 64'(LOAD_WORDS));
        chk("good load boot_done count", 64'(bd_cnt), 64'd1);
        chk("good load err", 64'(s_err), 64'd0);

        // Asynchronous reset while running.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset cpu_rst", 64'(cpu_rst), 64'd0);
        chk("async reset state", 64'(state), 64'd0);
        chk("async reset load_we", 64'(load_we), 64'd0);
        cmd_vld = 1'b0; hd_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("state after reset release", 64'(s_state), 64'd0);

        // Bad checksum.
        wr_cnt = 0; bd_cnt = 0;
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        stream_count(LOAD_WORDS);
        cycle(1'b0, 2'd0, 1'b1, 16'hFE01);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("bad csum boot_done count", 64'(bd_cnt), 64'd0);
        chk("bad csum state", 64'(s_state), 64'd5);
        chk("bad csum err", 64'(s_err), 64'd1);
        chk("bad csum cpu_rst", 64'(s_crst), 64'd0);
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("start clears err", 64'(s_err), 64'd0);

        // hd_vld toggling every cycle.
        wr_cnt = 0; bd_cnt = 0; words = 0; sum = 0; i = 0;
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        while (words < LOAD_WORDS) begin
            hv = (i % 2 == 0);
            d  = 16'($urandom);
            cycle(1'b0, 2'd0, hv, d);
            if (hv) begin sum = (sum + int'(d)) % 65536; words++; end
            i++;
        end
        cycle(1'b0, 2'd0, 1'b1, 16'(sum));
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("toggle write count", 64'(wr_cnt), 64'(LOAD_WORDS));
        chk("toggle boot_done count", 64'(bd_cnt), 64'd1);
        chk("toggle no timeout", 64'(s_err), 64'd0);

        // Host stall after word 100.
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        stream_count(101);
        t = cyc; found = 1'b0; edges = -1;
        for (int k = 0; k < TIMEOUT + 10 && !found; k++) begin
            cycle(1'b0, 2'd0, 1'b0, 16'd0);
            if (s_state == 3'd5) begin found = 1'b1; edges = cyc - t - 1; end
        end
        chk("stall timeout edges", 64'(edges), 64'(TIMEOUT));
        chk("stall err", 64'(s_err), 64'd1);

        // Stop at word 500 with hd_vld held high.
        cycle(1'b1, 2'd1, 1'b0, 16'd0);
        stream_count(500);
        wr_cnt = 0;
        cycle(1'b1, 2'd3, 1'b1, 16'd500);
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 1'b1, 16'(501 + k));
        chk("writes after stop", 64'(wr_cnt), 64'd0);
        chk("stop state", 64'(s_state), 64'd0);
        cycle(1'b1, 2'd2, 1'b0, 16'd0);
        cycle(1'b0, 2'd0, 1'b0, 16'd0);
        chk("run after stopped load state", 64'(s_state), 64'd5);
        chk("run after stopped load err", 64'(s_err), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 20000; n++) begin
            if (m_st == 1 || m_st == 2) cv = ($urandom % 1500 == 0);
            else                        cv = ($urandom % 8 == 0);
            c  = 2'($urandom % 4);
            hv = ($urandom % 4 != 0);
            if (m_st == 2 && ($urandom % 2 == 0)) d = 16'(m_sum);
            else                                  d = 16'($urandom);
            cycle(cv, c, hv, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
